fp_addsub_pipe: RTL and testbench
=================================

FP_ADDSUB_PIPE -- requirements
Module: fp_addsub_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 SHALL have parameter MAN_W, default 23, stored mantissa width; word width W = 1+EXP_W+MAN_W.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port n_rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operand pair valid.
REQ-006 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-007 SHALL have port op_a, op_b  input  W each  IEEE-style operands.
REQ-008 SHALL have port sub  input  1  1 = compute op_a - op_b; 0 = op_a + op_b.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port result  output  W  packed sum/difference.
REQ-012 SHALL have port flags  output  3  {invalid, overflow, underflow} for result.

Function
REQ-013 SHALL transfer input when in_valid && in_ready, output when out_valid && out_ready.
REQ-014 SHALL be a 3-stage pipeline: S1 unpack/compare/swap/align, S2 add or subtract magnitudes, S3 normalise/round/pack; latency exactly 3 cycles with no stall.
REQ-015 SHALL sustain one operation per cycle; in_ready = out_ready || !out_valid (whole pipeline stalls together; no bubble collapse).
REQ-016 SHALL hold result/flags/out_valid stable while out_valid && !out_ready.
REQ-017 SHALL deliver results in input order, none dropped or duplicated under any in_valid/out_ready pattern.
REQ-018 SHALL effective-sign op_b by XOR with sub, order operands by magnitude (exp then mantissa), result sign = larger-magnitude sign.
REQ-019 SHALL right-shift smaller mantissa (hidden 1 included) by exponent difference, keeping guard, round and sticky bits; shift >= MAN_W+3 yields sticky only.
REQ-020 SHALL use MAN_W+4-bit adder path; carry-out right-shifts one and increments exponent.
REQ-021 SHALL normalise cancellation results by leading-zero count, decrementing exponent accordingly.
REQ-022 SHALL treat subnormal inputs as signed zero (flush-to-zero); result exponent <= 0 after normalise gives signed zero, underflow=1.
REQ-023 SHALL give +0 for exact cancellation (x - x), flags 0; zero +/- zero follows IEEE sign (-0 only for -0 + -0).
REQ-024 SHALL give ±infinity, overflow=1, when result exponent reaches all-ones.
REQ-025 SHALL propagate infinity operand unchanged; inf - inf of like sign, or any NaN input, gives canonical quiet NaN (sign 0, exp all-ones, mantissa MSB 1, rest 0), invalid=1.
REQ-026 SHALL present flags together with the matching result word.

Reset
REQ-027 SHALL, on n_rst=0 at clock edge, clear all stage valid bits; out_valid=0, result=0, flags=0, in_ready=1 in following cycle.
REQ-028 SHALL discard in-flight operations on reset mid-operation; no result for them emerges after reset.

Configuration
REQ-029 SHALL, with macro FP_ADDSUB_RNE_EN defined, round to nearest, ties to even, using guard/round/sticky; rounding carry renormalises and may cause overflow.
REQ-030 SHALL, without FP_ADDSUB_RNE_EN, truncate (round toward zero); guard/round/sticky logic removed; latency unchanged.

Structure
REQ-031 SHALL place in shared package fp_pkg: unpacked operand struct (sign, exp, mant, is_zero, is_inf, is_nan), flag index constants, canonical-NaN function of EXP_W/MAN_W.
REQ-032 SHALL implement S3 in sub-module fp_norm_round (leading-zero count, normalise, round, pack, overflow/underflow).

Verification
REQ-033 SHALL check 0x3F800000 + 0x3F800000 -> 0x40000000, flags 000, out_valid exactly 3 cycles after accept.
REQ-034 SHALL check 0x3F800000 - 0x3F800000 (sub=1) -> 0x00000000; 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, overflow=1.
REQ-035 SHALL check RNE: 0x3F800000 + 0x33800000 -> 0x3F800000 (tie to even); 0x3F800000 + 0x33800001 -> 0x3F800001; without macro both -> 0x3F800000.
REQ-036 SHALL check 0x7F800000 - 0x7F800000 (sub=1) -> 0x7FC00000, invalid=1; 0x00000001 + 0x00000000 -> 0x00000000.
REQ-037 SHALL check 8 back-to-back ops with out_ready low for cycles 4-6: in_ready low during stall, all 8 results in order, held stable while stalled.
REQ-038 SHALL check n_rst pulsed low with 3 ops in flight: out_valid=0 next cycle, no stale results afterwards.

Source files
------------

// File: rtl/fp_pkg.sv
// fp_pkg: shared operand struct, flag bit positions and canonical quiet-NaN builder
package fp_pkg;
  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;
  localparam int FLAG_INV = 2;
  localparam int FLAG_OVF = 1;
  localparam int FLAG_UNF = 0;
  typedef struct packed {
    logic sign;
    logic [FP_EXP_W-1:0] exp;
    logic [FP_MAN_W-1:0] mant;
    logic is_zero;
    logic is_inf;
    logic is_nan;
  } fp_unpacked_t;
  function automatic logic [63:0] canon_nan(input int exp_w, input int man_w);
    return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
  endfunction
endpackage

// File: rtl/fp_norm_round.sv
// fp_norm_round: normalise, round and pack a raw magnitude sum; FP_ADDSUB_RNE_EN selects round-to-nearest-even, otherwise truncation
module fp_norm_round import fp_pkg::*; #(
  parameter int EXP_W = FP_EXP_W,
  parameter int MAN_W = FP_MAN_W,
  localparam int W = 1 + EXP_W + MAN_W,
  localparam int SW = MAN_W + 4,
  localparam int LZ_W = $clog2(SW + 1)
) (
  input logic sign,
  input logic [EXP_W-1:0] exp,
  input logic [SW:0] sum,
  input logic sp_en,
  input logic [W-1:0] sp_word,
  input logic [2:0] sp_flags,
  output logic [W-1:0] word,
  output logic [2:0] flags
);
  localparam logic signed [EXP_W+1:0] EMAX = (EXP_W+2)'((1 << EXP_W) - 1);
  logic [LZ_W-1:0] lz;
  logic [SW-1:0] m;
  logic signed [EXP_W+1:0] ex;
  logic signed [EXP_W+1:0] ex_r;
  logic inc;
  logic [MAN_W+1:0] mr;
  // leading-zero count of the carry-free sum; the highest set bit wins
  always_comb begin
    lz = '0;
    for (int i = 0; i < SW; i++) if (sum[i]) lz = LZ_W'(SW - 1 - i);
  end
  assign m = sum[SW] ? {sum[SW:2], sum[1] | sum[0]} : sum[SW-1:0] << lz;
  assign ex = (EXP_W+2)'(exp) + (sum[SW] ? (EXP_W+2)'(1) : -(EXP_W+2)'(lz));
`ifdef FP_ADDSUB_RNE_EN
  assign inc = m[2] & (m[1] | m[0] | m[3]);
`else
  logic unused_grs;
  assign inc = 1'b0;
  assign unused_grs = ^m[2:0];
`endif
  assign mr = {1'b0, m[SW-1:3]} + (MAN_W+2)'(inc);
  assign ex_r = ex + (EXP_W+2)'(mr[MAN_W+1]);
  assign word = sp_en ? sp_word
    : ~|sum ? '0
    : ex <= 0 ? {sign, {(W-1){1'b0}}}
    : ex_r >= EMAX ? {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
    : {sign, ex_r[EXP_W-1:0], mr[MAN_W-1:0]};
  assign flags = sp_en ? sp_flags
    : ~|sum ? 3'b000
    : ex <= 0 ? 3'(1) << FLAG_UNF
    : ex_r >= EMAX ? 3'(1) << FLAG_OVF
    : 3'b000;
endmodule

// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: 3-stage floating-point add/subtract with valid/ready flow control; define FP_ADDSUB_RNE_EN for round-to-nearest-even
module fp_addsub_pipe import fp_pkg::*; #(
  parameter int EXP_W = FP_EXP_W,
  parameter int MAN_W = FP_MAN_W,
  localparam int W = 1 + EXP_W + MAN_W,
  localparam int SW = MAN_W + 4
) (
  input logic clk,
  input logic n_rst,
  input logic in_valid,
  output logic in_ready,
  input logic [W-1:0] op_a,
  input logic [W-1:0] op_b,
  input logic sub,
  output logic out_valid,
  input logic out_ready,
  output logic [W-1:0] result,
  output logic [2:0] flags
);
  logic adv;
  fp_unpacked_t ua;
  fp_unpacked_t ub;
  logic swap;
  logic [SW-1:0] sa_sig;
  logic [SW-1:0] sb_sig;
  logic [SW-1:0] big_sig;
  logic [SW-1:0] sml_sig;
  logic [SW-1:0] sml_al;
  logic [EXP_W-1:0] ediff;
  logic sp_nan;
  logic sp_en;
  logic [W-1:0] sp_word;
  logic [2:0] sp_flags;
  logic v1;
  logic v2;
  logic s1_sign;
  logic s1_sub;
  logic s1_sp;
  logic [EXP_W-1:0] s1_exp;
  logic [SW-1:0] s1_big;
  logic [SW-1:0] s1_sml;
  logic [W-1:0] s1_spw;
  logic [2:0] s1_spf;
  logic s2_sign;
  logic s2_sp;
  logic [EXP_W-1:0] s2_exp;
  logic [SW:0] s2_sum;
  logic [W-1:0] s2_spw;
  logic [2:0] s2_spf;
  logic [W-1:0] nr_word;
  logic [2:0] nr_flags;
  function automatic fp_unpacked_t unpack(input logic [W-1:0] x, input logic neg);
    fp_unpacked_t u;
    u.sign = x[W-1] ^ neg;
    u.exp = x[MAN_W +: EXP_W];
    u.mant = x[MAN_W-1:0];
    u.is_zero = u.exp == '0;
    u.is_inf = &u.exp && u.mant == '0;
    u.is_nan = &u.exp && u.mant != '0;
    return u;
  endfunction
  assign adv = out_ready || !out_valid;
  assign in_ready = adv;
  assign ua = unpack(op_a, 1'b0);
  assign ub = unpack(op_b, sub);
  assign swap = {ub.exp, ub.mant} > {ua.exp, ua.mant};
  assign sa_sig = ua.is_zero ? '0 : {1'b1, ua.mant, 3'b000};
  assign sb_sig = ub.is_zero ? '0 : {1'b1, ub.mant, 3'b000};
  assign big_sig = swap ? sb_sig : sa_sig;
  assign sml_sig = swap ? sa_sig : sb_sig;
  assign ediff = swap ? ub.exp - ua.exp : ua.exp - ub.exp;
  assign sml_al = int'(ediff) < SW - 1
    ? (sml_sig >> ediff) | SW'(|(sml_sig & ((SW'(1) << ediff) - SW'(1))))
    : SW'(|sml_sig);
  assign sp_nan = ua.is_nan || ub.is_nan || (ua.is_inf && ub.is_inf && ua.sign != ub.sign);
  assign sp_en = sp_nan || ua.is_inf || ub.is_inf || (ua.is_zero && ub.is_zero);
  assign sp_word = sp_nan ? W'(canon_nan(EXP_W, MAN_W))
    : ua.is_inf ? {ua.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
    : ub.is_inf ? {ub.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
    : {ua.sign & ub.sign, {(W-1){1'b0}}};
  assign sp_flags = 3'(sp_nan) << FLAG_INV;
  // stage valids and the registered output advance together whenever the output is free
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      out_valid <= 1'b0;
      result <= '0;
      flags <= '0;
    end else if (adv) begin
      v1 <= in_valid;
      v2 <= v1;
      out_valid <= v2;
      result <= nr_word;
      flags <= nr_flags;
    end
  end
  // S1: ordered, aligned significands plus any special-case result
  always_ff @(posedge clk) begin
    if (adv) begin
      s1_sign <= swap ? ub.sign : ua.sign;
      s1_sub <= ua.sign ^ ub.sign;
      s1_exp <= swap ? ub.exp : ua.exp;
      s1_big <= big_sig;
      s1_sml <= sml_al;
      s1_sp <= sp_en;
      s1_spw <= sp_word;
      s1_spf <= sp_flags;
    end
  end
  // S2: magnitude add or subtract; the larger operand is first so no borrow can occur
  always_ff @(posedge clk) begin
    if (adv) begin
      s2_sign <= s1_sign;
      s2_exp <= s1_exp;
      s2_sum <= s1_sub ? {1'b0, s1_big} - {1'b0, s1_sml} : {1'b0, s1_big} + {1'b0, s1_sml};
      s2_sp <= s1_sp;
      s2_spw <= s1_spw;
      s2_spf <= s1_spf;
    end
  end
  fp_norm_round #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_norm (
    .sign(s2_sign),
    .exp(s2_exp),
    .sum(s2_sum),
    .sp_en(s2_sp),
    .sp_word(s2_spw),
    .sp_flags(s2_spf),
    .word(nr_word),
    .flags(nr_flags)
  );
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// tb_fp_addsub_pipe: directed-vector scoreboard bench for fp_addsub_pipe
module tb_fp_addsub_pipe;
`ifdef FP_ADDSUB_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic sub = 1'b0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [31:0] result;
  logic [2:0] flags;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  bit stalled = 1'b0;
  typedef struct { logic [31:0] a; logic [31:0] b; logic s; logic [31:0] r; logic [2:0] f; } vec_t;
  typedef struct { logic [31:0] res; logic [2:0] flg; int issue; bit lat; } exp_t;
  vec_t vecs[$];
  exp_t q[$];

  fp_addsub_pipe dut (
    .clk(clk),
    .n_rst(n_rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .op_a(op_a),
    .op_b(op_b),
    .sub(sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result(result),
    .flags(flags)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // monitor: compare the presented output against the scoreboard head, pop on handshake
  always @(negedge clk) begin
    if (n_rst && stalled) check("held_valid", out_valid, 1);
    if (n_rst && out_valid) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: got %h expected none (cycle %0d)", result, cyc);
      end else begin
        check("result", result, q[0].res);
        check("flags", flags, q[0].flg);
        if (out_ready) begin
          if (q[0].lat) check("latency", cyc - q[0].issue, 3);
          void'(q.pop_front());
        end
      end
    end
    stalled = n_rst && out_valid && !out_ready;
  end

  task automatic issue(input vec_t v, input bit lat);
    bit done = 1'b0;
    in_valid = 1'b1;
    op_a = v.a;
    op_b = v.b;
    sub = v.s;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back('{v.r, v.f, cyc, lat});
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: in_ready stayed 0, expected 1 within 20 cycles");
    end
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int k = 0; k < 50 && q.size() != 0; k++) @(posedge clk);
    #1;
    check("drain_outstanding", q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs.push_back('{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000});
    vecs.push_back('{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000});
    vecs.push_back('{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b010});
    vecs.push_back('{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b000});
    vecs.push_back('{32'h3F800000, 32'h33800001, 1'b0, RNE ? 32'h3F800001 : 32'h3F800000, 3'b000});
    vecs.push_back('{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 3'b000});
    vecs.push_back('{32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 3'b000});
    vecs.push_back('{32'h3F800000, 32'h33800000, 1'b1, 32'h3F7FFFFF, 3'b000});
    vecs.push_back('{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b100});
    vecs.push_back('{32'h00000001, 32'h00000000, 1'b0, 32'h00000000, 3'b000});
    vecs.push_back('{32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 3'b000});
    vecs.push_back('{32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b100});
    vecs.push_back('{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000});
    vecs.push_back('{32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 3'b000});
    vecs.push_back('{32'h00800000, 32'h00C00000, 1'b1, 32'h80000000, 3'b001});
    vecs.push_back('{32'h3F800000, 32'h0D800000, 1'b0, 32'h3F800000, 3'b000});
    vecs.push_back('{32'h3FFFFFFF, 32'h33800000, 1'b0, RNE ? 32'h40000000 : 32'h3FFFFFFF, 3'b000});
    vecs.push_back('{32'h7F7FFFFF, 32'h73000000, 1'b0, RNE ? 32'h7F800000 : 32'h7F7FFFFF, RNE ? 3'b010 : 3'b000});
    vecs.push_back('{32'h3F800000, 32'hBF800000, 1'b1, 32'h40000000, 3'b000});
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b1;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_result", result, 0);
    check("rst_flags", flags, 0);
    @(posedge clk);
    #1;
    foreach (vecs[i]) issue(vecs[i], 1'b1);
    drain();
    @(posedge clk);
    #1;
    fork
      for (int i = 0; i < 8; i++) issue(vecs[i], 1'b0);
      for (int r = 0; r < 10; r++) begin
        out_ready = !(r >= 4 && r <= 6);
        @(negedge clk);
        check("stall_in_ready", in_ready, r < 4 || r > 6);
        @(posedge clk);
        #1;
      end
    join
    out_ready = 1'b1;
    drain();
    @(posedge clk);
    #1;
    issue(vecs[0], 1'b1);
    issue(vecs[5], 1'b1);
    issue(vecs[6], 1'b1);
    in_valid = 1'b0;
    out_ready = 1'b0;
    n_rst = 1'b0;
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    out_ready = 1'b1;
    q.delete();
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_result", result, 0);
    check("midrst_flags", flags, 0);
    repeat (8) @(posedge clk);
    #1;
    issue(vecs[2], 1'b1);
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
